// File: rtl/fifo_p_32to8.sv
`timescale 1ns/1ps
// fifo_p_32to8
// Packet FIFO with 32-bit to 8-bit width conversion. Framed 32-bit words
// (sop/eop/mty) are stored as 36-bit entries {sop, eop, mty, din}. Each
// packet is replayed as a byte stream, most significant byte first, with
// byte-accurate sop/eop.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous reset, active-high (asserted when 1)
//   din[31:0]     input word, din[31:24] is the first byte on the wire
//   din_vld       din/sop/eop/mty valid this cycle
//   din_sop       first word of packet (qualified by din_vld)
//   din_eop       last word of packet (qualified by din_vld)
//   din_mty[1:0]  invalid low-order bytes in the eop word (ignored if eop=0)
//   dout[7:0]     output byte (0 when dout_vld=0)
//   dout_vld      dout valid
//   dout_sop      first byte of packet
//   dout_eop      last valid byte of packet
//   rd_state_dbg  read FSM state (0 = IDLE, 1 = SHIFT)
//   drop_cnt      rejected-packet counter, saturating (only with the
//                 FIFO_P_DROP_CNT_EN macro defined)
//
// Handshake: neither side has a ready. A din_vld word is either stored or
// discarded by packet admission in the same cycle; dout_vld marks a byte for
// exactly one cycle and the sink must always take it.
module fifo_p_32to8 #(
  parameter int DEPTH   = 4096,
  parameter int MAX_PKT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic [1:0]  din_mty,
  output logic [7:0]  dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        rd_state_dbg
`ifdef FIFO_P_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] MAX_W   = (AW+1)'(MAX_PKT);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } rd_state_t;

  // ---------------------------------------------------------------
  // Storage and pointers (extra MSB distinguishes full from empty)
  // ---------------------------------------------------------------
  logic [35:0] mem [DEPTH];
  logic [35:0] rd_word;
  logic [AW:0] wr_ptr, rd_ptr, used;
  logic        empty, full, sop_admit, wr_en, pop;

  assign used      = wr_ptr - rd_ptr;
  assign empty     = (used == '0);
  assign full      = (used == DEPTH_W);
  // Free space is judged before this cycle's write and pop.
  assign sop_admit = ((DEPTH_W - used) >= MAX_W);

  // ---------------------------------------------------------------
  // Write side: packet admission
  // ---------------------------------------------------------------
  logic pkt_open;  // a sop has been seen and its eop has not
  logic pkt_keep;  // admit/drop decision of the open packet

  always_comb begin
    wr_en = 1'b0;
    if (din_vld && !full) begin
      if (din_sop) wr_en = sop_admit;
      else         wr_en = pkt_open && pkt_keep;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pkt_open <= 1'b0;
      pkt_keep <= 1'b0;
      wr_ptr   <= '0;
    end else begin
      if (din_vld) begin
        if (din_sop) begin
          // A sop always starts a fresh decision, even mid-packet.
          pkt_keep <= sop_admit;
          pkt_open <= !din_eop;
        end else if (din_eop) begin
          pkt_open <= 1'b0;
        end
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
    end
  end

`ifdef FIFO_P_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      drop_cnt <= '0;
    end else if (din_vld && din_sop && !sop_admit && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  // Memory without reset so it maps onto block RAM; the read port is
  // registered and doubles as the shift register holding the current word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {din_sop, din_eop, din_mty, din};
    if (pop)   rd_word <= mem[rd_ptr[AW-1:0]];
  end

  // ---------------------------------------------------------------
  // Read side: byte serialiser
  // ---------------------------------------------------------------
  rd_state_t  state, state_nxt;
  logic [1:0] idx, idx_nxt, last_idx;
  logic [7:0] byte_sel, dout_nxt;
  logic       vld_nxt, sop_nxt, eop_nxt;
  logic       w_sop, w_eop;
  logic [1:0] w_mty;

  assign w_sop        = rd_word[35];
  assign w_eop        = rd_word[34];
  assign w_mty        = rd_word[33:32];
  assign last_idx     = w_eop ? (2'd3 - w_mty) : 2'd3;
  assign rd_state_dbg = state;

  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      2'd0:    byte_sel = rd_word[31:24];
      2'd1:    byte_sel = rd_word[23:16];
      2'd2:    byte_sel = rd_word[15:8];
      default: byte_sel = rd_word[7:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pop       = 1'b0;
    dout_nxt  = 8'h00;
    vld_nxt   = 1'b0;
    sop_nxt   = 1'b0;
    eop_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          idx_nxt   = 2'd0;
          state_nxt = S_SHIFT;
        end
      end
      default: begin
        vld_nxt  = 1'b1;
        dout_nxt = byte_sel;
        sop_nxt  = w_sop && (idx == 2'd0);
        eop_nxt  = w_eop && (idx == last_idx);
        if (idx == last_idx) begin
          idx_nxt = 2'd0;
          // Fetch the next word on the last byte so words run back-to-back.
          if (!empty) pop = 1'b1;
          else        state_nxt = S_IDLE;
        end else begin
          idx_nxt = idx + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= S_IDLE;
      idx      <= 2'd0;
      rd_ptr   <= '0;
      dout     <= 8'h00;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      dout     <= dout_nxt;
      dout_vld <= vld_nxt;
      dout_sop <= sop_nxt;
      dout_eop <= eop_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_p_32to8.sv
`timescale 1ns/1ps
module tb_fifo_p_32to8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        din_vld = 1'b0;
  logic        din_sop = 1'b0;
  logic        din_eop = 1'b0;
  logic [1:0]  din_mty = 2'd0;
  logic [7:0]  dout;
  logic        dout_vld, dout_sop, dout_eop;
  logic        rd_state_dbg;
`ifdef FIFO_P_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_p_32to8 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_vld      (din_vld),
    .din_sop      (din_sop),
    .din_eop      (din_eop),
    .din_mty      (din_mty),
    .dout         (dout),
    .dout_vld     (dout_vld),
    .dout_sop     (dout_sop),
    .dout_eop     (dout_eop),
    .rd_state_dbg (rd_state_dbg)
`ifdef FIFO_P_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];   // {sop, eop, byte}
  logic [9:0] exp_e;
  int   byte_cnt = 0, sop_cnt = 0, eop_cnt = 0, bubbles = 0, sop_cyc = 0;
  logic in_pkt = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      in_pkt = 1'b0;
    end else if (dout_vld) begin
      byte_cnt++;
      if (dout_sop) begin sop_cnt++; sop_cyc = cyc; in_pkt = 1'b1; end
      if (dout_eop) eop_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL byte_unexpected: got sop=%0b eop=%0b dout=%02h, required no byte",
                 dout_sop, dout_eop, dout);
      end else begin
        exp_e = exp_q.pop_front();
        if ({dout_sop, dout_eop, dout} !== exp_e) begin
          n_err++;
          $display("FAIL byte_stream: got sop=%0b eop=%0b dout=%02h, required sop=%0b eop=%0b dout=%02h",
                   dout_sop, dout_eop, dout, exp_e[9], exp_e[8], exp_e[7:0]);
        end
      end
      if (dout_eop) in_pkt = 1'b0;
    end else begin
      if (in_pkt) bubbles++;
      n_vec++;
      if ({dout_sop, dout_eop, dout} !== 10'd0) begin
        n_err++;
        $display("FAIL idle_outputs: got sop=%0b eop=%0b dout=%02h, required all 0",
                 dout_sop, dout_eop, dout);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input logic s, input logic e,
                           input logic [1:0] m);
    din = d; din_sop = s; din_eop = e; din_mty = m; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_mty = 2'd0;
  endtask

  // Expected byte sequence of one stored word.
  task automatic push_exp(input logic [31:0] d, input logic s, input logic e,
                          input logic [1:0] m);
    int last;
    last = e ? 3 - int'(m) : 3;
    for (int i = 0; i <= last; i++)
      exp_q.push_back({(s && i == 0), (e && i == last), d[31-8*i -: 8]});
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    #1;
    idle_cycles(8);
  endtask

  task automatic clear_stats();
    byte_cnt = 0; sop_cnt = 0; eop_cnt = 0; bubbles = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_vec++;
    if ({dout_vld, dout_sop, dout_eop, dout} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got vld=%0b sop=%0b eop=%0b dout=%02h, required 0",
               dout_vld, dout_sop, dout_eop, dout);
    end
    n_vec++;
    if (rd_state_dbg !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got %0b, required 0", rd_state_dbg);
    end
`ifdef FIFO_P_DROP_CNT_EN
    n_vec++;
    if (drop_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_three_word(input logic [1:0] mty);
    logic [31:0] w [3];
    int wr_cyc;
    w[0] = 32'h11223344; w[1] = 32'h55667788; w[2] = 32'h99AABBCC;
    clear_stats();
    for (int i = 0; i < 3; i++) push_exp(w[i], i == 0, i == 2, (i == 2) ? mty : 2'd0);
    send_word(w[0], 1'b1, 1'b0, 2'd0);
    wr_cyc = cyc;
    send_word(w[1], 1'b0, 1'b0, 2'd0);
    send_word(w[2], 1'b0, 1'b1, mty);
    wait_drain(100);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL three_word_drain: %0d bytes missing, required 0", exp_q.size());
      exp_q.delete();
    end
    n_vec++;
    if (byte_cnt != 12 - int'(mty)) begin
      n_err++; $display("FAIL three_word_len: got %0d bytes, required %0d", byte_cnt, 12 - int'(mty));
    end
    n_vec++;
    if (sop_cyc - wr_cyc != 2) begin
      n_err++; $display("FAIL three_word_latency: got %0d cycles, required 2", sop_cyc - wr_cyc);
    end
    n_vec++;
    if (bubbles != 0) begin
      n_err++; $display("FAIL three_word_bubbles: got %0d, required 0", bubbles);
    end
    n_vec++;
    if (rd_state_dbg !== 1'b0) begin
      n_err++; $display("FAIL three_word_idle: state %0b, required 0", rd_state_dbg);
    end
  endtask

  task automatic test_single_word();
    clear_stats();
    push_exp(32'hDEADBEEF, 1'b1, 1'b1, 2'd3);
    send_word(32'hDEADBEEF, 1'b1, 1'b1, 2'd3);
    wait_drain(50);
    n_vec++;
    if (exp_q.size() != 0 || byte_cnt != 1 || sop_cnt != 1 || eop_cnt != 1) begin
      n_err++;
      $display("FAIL single_word: got bytes=%0d sops=%0d eops=%0d left=%0d, required 1 1 1 0",
               byte_cnt, sop_cnt, eop_cnt, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_framing();
    clear_stats();
    // Outside any packet: discarded.
    send_word(32'hAAAAAAAA, 1'b0, 1'b0, 2'd0);
    send_word(32'h0BADF00D, 1'b0, 1'b1, 2'd1);
    // Flags without din_vld: never written.
    din = 32'hFEEDFACE; din_sop = 1'b1; din_eop = 1'b1;
    idle_cycles(1);
    din_sop = 1'b0; din_eop = 1'b0;
    // Packet A never sees its eop; mty on a non-eop word is ignored.
    push_exp(32'h01020304, 1'b1, 1'b0, 2'd0);
    push_exp(32'h05060708, 1'b0, 1'b0, 2'd0);
    push_exp(32'h0A0B0C0D, 1'b1, 1'b1, 2'd1);
    send_word(32'h01020304, 1'b1, 1'b0, 2'd3);
    send_word(32'h05060708, 1'b0, 1'b0, 2'd0);
    send_word(32'h0A0B0C0D, 1'b1, 1'b1, 2'd1);
    wait_drain(100);
    n_vec++;
    if (exp_q.size() != 0 || byte_cnt != 11) begin
      n_err++;
      $display("FAIL framing: got bytes=%0d left=%0d, required 11 0", byte_cnt, exp_q.size());
      exp_q.delete();
    end
    n_vec++;
    if (sop_cnt != 2 || eop_cnt != 1) begin
      n_err++; $display("FAIL framing_flags: got sops=%0d eops=%0d, required 2 1", sop_cnt, eop_cnt);
    end
  endtask

  task automatic test_reset_mid_stream();
    int n, wr_cyc;
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      push_exp(32'hC0C1C2C3 + 32'(i), i == 0, i == 3, 2'd0);
      send_word(32'hC0C1C2C3 + 32'(i), i == 0, i == 3, 2'd0);
    end
    n = 0;
    while (byte_cnt < 3 && n < 50) begin @(posedge clk); n++; end
    #1;
    n_vec++;
    if (byte_cnt < 3) begin
      n_err++; $display("FAIL reset_pre_stream: got %0d bytes, required >= 3", byte_cnt);
    end
    #2 rst_n = 1'b1;
    exp_q.delete();
    #1;
    n_vec++;
    if ({dout_vld, dout_sop, dout_eop, dout} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_async: got vld=%0b sop=%0b eop=%0b dout=%02h, required 0",
               dout_vld, dout_sop, dout_eop, dout);
    end
    // Inputs during reset are ignored.
    din = 32'h77777777; din_vld = 1'b1; din_sop = 1'b1; din_eop = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    rst_n = 1'b0;
    clear_stats();
    idle_cycles(10);
    n_vec++;
    if (byte_cnt != 0 || rd_state_dbg !== 1'b0) begin
      n_err++; $display("FAIL reset_flushed: got bytes=%0d state=%0b, required 0 0", byte_cnt, rd_state_dbg);
    end
    push_exp(32'h12345678, 1'b1, 1'b1, 2'd0);
    send_word(32'h12345678, 1'b1, 1'b1, 2'd0);
    wr_cyc = cyc;
    wait_drain(50);
    n_vec++;
    if (exp_q.size() != 0 || byte_cnt != 4 || sop_cyc - wr_cyc != 2) begin
      n_err++;
      $display("FAIL reset_restart: got bytes=%0d left=%0d latency=%0d, required 4 0 2",
               byte_cnt, exp_q.size(), sop_cyc - wr_cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_long_packets();
    logic [1:0] mty;
    int total;
    clear_stats();
    total = 0;
    for (int p = 0; p < 5; p++) begin
      mty = 2'($urandom_range(0, 3));
      total += 3204 - int'(mty);
      for (int w = 0; w <= 800; w++) begin
        push_exp(32'(w), w == 0, w == 800, (w == 800) ? mty : 2'd0);
        send_word(32'(w), w == 0, w == 800, (w == 800) ? mty : 2'd0);
      end
      idle_cycles(250);
    end
    wait_drain(20000);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL long_drain: %0d bytes missing, required 0", exp_q.size());
      exp_q.delete();
    end
    n_vec++;
    if (byte_cnt != total || sop_cnt != 5 || eop_cnt != 5) begin
      n_err++;
      $display("FAIL long_count: got bytes=%0d sops=%0d eops=%0d, required %0d 5 5",
               byte_cnt, sop_cnt, eop_cnt, total);
    end
    n_vec++;
    if (bubbles != 0) begin
      n_err++; $display("FAIL long_bubbles: got %0d, required 0", bubbles);
    end
  endtask

  task automatic test_drop();
    int total;
    clear_stats();
    total = 0;
    // Five back-to-back 1000-word packets leave under MAX_PKT words free.
    for (int p = 0; p < 5; p++) begin
      for (int w = 0; w < 1000; w++) begin
        push_exp({8'(p), 24'(w)}, w == 0, w == 999, (w == 999) ? 2'(p) : 2'd0);
        send_word({8'(p), 24'(w)}, w == 0, w == 999, (w == 999) ? 2'(p) : 2'd0);
      end
      total += 4000 - (p % 4);
    end
`ifdef FIFO_P_DROP_CNT_EN
    n_vec++;
    if (drop_cnt !== 16'd0) begin
      n_err++; $display("FAIL drop_cnt_before: got %0d, required 0", drop_cnt);
    end
`endif
    // Rejected packet: none of its words may appear.
    for (int w = 0; w < 8; w++)
      send_word(32'hDD000000 + 32'(w), w == 0, w == 7, 2'd0);
`ifdef FIFO_P_DROP_CNT_EN
    n_vec++;
    if (drop_cnt !== 16'd1) begin
      n_err++; $display("FAIL drop_cnt_after: got %0d, required 1", drop_cnt);
    end
`endif
    idle_cycles(3000);
    for (int w = 0; w < 4; w++) begin
      push_exp(32'hEE000000 + 32'(w), w == 0, w == 3, 2'd0);
      send_word(32'hEE000000 + 32'(w), w == 0, w == 3, 2'd0);
    end
    total += 16;
    wait_drain(30000);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL drop_drain: %0d bytes missing, required 0", exp_q.size());
      exp_q.delete();
    end
    n_vec++;
    if (byte_cnt != total || sop_cnt != 6 || eop_cnt != 6 || bubbles != 0) begin
      n_err++;
      $display("FAIL drop_count: got bytes=%0d sops=%0d eops=%0d bubbles=%0d, required %0d 6 6 0",
               byte_cnt, sop_cnt, eop_cnt, bubbles, total);
    end
`ifdef FIFO_P_DROP_CNT_EN
    n_vec++;
    if (drop_cnt !== 16'd1) begin
      n_err++; $display("FAIL drop_cnt_final: got %0d, required 1", drop_cnt);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #1 rst_n = 1'b1;
    #2;
    test_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    idle_cycles(2);
    test_three_word(2'd0);
    test_three_word(2'd2);
    test_single_word();
    test_framing();
    test_reset_mid_stream();
    test_long_packets();
    test_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
